// File: rtl/enemy_pkg.sv
// Shared encodings for the enemy boxer: FSM states, lanes and lane-to-screen-x mapping.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package enemy_pkg;

  // FSM state encodings, also exported on the state port for the renderer
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_TRACK   = 3'd1;
  localparam logic [2:0] S_WINDUP  = 3'd2;
  localparam logic [2:0] S_STRIKE  = 3'd3;
  localparam logic [2:0] S_RECOVER = 3'd4;
  localparam logic [2:0] S_STUN    = 3'd5;

  // Lanes, left to right
  localparam logic [1:0] LANE_L = 2'd0;
  localparam logic [1:0] LANE_M = 2'd1;
  localparam logic [1:0] LANE_R = 2'd2;

  // Default timing: one step per second at 100 MHz when slow
  localparam int DEF_PERIOD_SLOW   = 100000000;
  localparam int DEF_PERIOD_FAST   = 50000000;
  localparam int DEF_WINDUP_STEPS  = 2;
  localparam int DEF_RECOVER_STEPS = 2;
  localparam int DEF_STUN_STEPS    = 3;

  // Screen x coordinate for each lane, used by the enemy datapath
  function automatic logic [6:0] lane_to_x(input logic [1:0] lane);
    case (lane)
      LANE_L:  return 7'd20;
      LANE_M:  return 7'd60;
      default: return 7'd100;
    endcase
  endfunction

  // The player lane input has no fourth lane; treat 3 as the rightmost lane
  function automatic logic [1:0] clamp_lane(input logic [1:0] lane);
    return (lane == 2'd3) ? LANE_R : lane;
  endfunction

endpackage

// File: rtl/enemy_step_timer.sv
// Step timer: 28-bit down-counter producing a 1-cycle step every PERIOD cycles.
// Latency: first step PERIOD cycles after a reload; step is combinational off the count.
// Backpressure: none; speed is only sampled when the counter reloads.
module enemy_step_timer #(
  parameter int PERIOD_SLOW = 100000000,
  parameter int PERIOD_FAST = 50000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic reload,
  input  logic speed,
  output logic step
);

  localparam logic [27:0] SLOW_LAST = 28'(PERIOD_SLOW - 1);
  localparam logic [27:0] FAST_LAST = 28'(PERIOD_FAST - 1);

  logic [27:0] count;

  // Count down; restart on a state change or when the count runs out
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
    end else if (reload || (count == '0)) begin
      count <= speed ? FAST_LAST : SLOW_LAST;
    end else begin
      count <= count - 28'd1;
    end
  end

  assign step = (count == '0);

endmodule

// File: rtl/enemy_control.sv
// Enemy boxer sequencer: lane tracking, windup/strike/recover timing, stun on player hits.
// Latency: all outputs registered; state and pulses change one clock after the deciding inputs.
// Backpressure: none; start=0 and player_hit preempt any step-driven transition.
module enemy_control
  import enemy_pkg::*;
#(
  parameter int PERIOD_SLOW   = DEF_PERIOD_SLOW,
  parameter int PERIOD_FAST   = DEF_PERIOD_FAST,
  // Step limits are compared against a 2-bit dwell counter, so keep them in 1..3
  parameter int WINDUP_STEPS  = DEF_WINDUP_STEPS,
  parameter int RECOVER_STEPS = DEF_RECOVER_STEPS,
  parameter int STUN_STEPS    = DEF_STUN_STEPS
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       speed,
  input  logic [1:0] player_x,
  input  logic       player_block,
  input  logic       player_hit,
  output logic [1:0] x_pos,
  output logic [2:0] state,
  output logic       windup,
  output logic       strike,
  output logic       hit_player,
  output logic       blocked,
  output logic       stunned
);

  localparam logic [1:0] WINDUP_LAST  = 2'(WINDUP_STEPS - 1);
  localparam logic [1:0] RECOVER_LAST = 2'(RECOVER_STEPS - 1);
  localparam logic [1:0] STUN_LAST    = 2'(STUN_STEPS - 1);

  logic       step;
  logic       reload;
  logic [1:0] px;
  logic [2:0] state_nxt;
  logic [1:0] x_nxt;
  logic [1:0] dwell;
  logic [1:0] dwell_nxt;

  enemy_step_timer #(
    .PERIOD_SLOW(PERIOD_SLOW),
    .PERIOD_FAST(PERIOD_FAST)
  ) u_step_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .reload  (reload),
    .speed   (speed),
    .step    (step)
  );

  // Next-state, lane and dwell decisions; priority start=0 > player_hit > step
  always_comb begin
    px        = clamp_lane(player_x);
    state_nxt = state;
    x_nxt     = x_pos;
    if (!start) begin
      state_nxt = S_IDLE;
    end else if (player_hit && ((state == S_WINDUP) || (state == S_RECOVER))) begin
      state_nxt = S_STUN;
    end else begin
      case (state)
        S_IDLE:    state_nxt = S_TRACK;
        S_TRACK: begin
          if (step) begin
            if (x_pos == px)     state_nxt = S_WINDUP;
            else if (x_pos < px) x_nxt     = x_pos + 2'd1;
            else                 x_nxt     = x_pos - 2'd1;
          end
        end
        S_WINDUP:  if (step && (dwell == WINDUP_LAST))  state_nxt = S_STRIKE;
        S_STRIKE:  state_nxt = S_RECOVER;
        S_RECOVER: if (step && (dwell == RECOVER_LAST)) state_nxt = S_TRACK;
        S_STUN:    if (step && (dwell == STUN_LAST))    state_nxt = S_TRACK;
        default:   state_nxt = S_IDLE;
      endcase
    end
    // The enemy parks in the middle lane whenever the round is not running
    if (state_nxt == S_IDLE) x_nxt = LANE_M;
    reload    = (state_nxt != state);
    dwell_nxt = reload ? 2'd0 : (step ? dwell + 2'd1 : dwell);
  end

  // Register state, lane, dwell and all outputs; the strike is resolved on the edge entering STRIKE
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      x_pos      <= LANE_M;
      dwell      <= 2'd0;
      windup     <= 1'b0;
      strike     <= 1'b0;
      hit_player <= 1'b0;
      blocked    <= 1'b0;
      stunned    <= 1'b0;
    end else begin
      state      <= state_nxt;
      x_pos      <= x_nxt;
      dwell      <= dwell_nxt;
      windup     <= (state_nxt == S_WINDUP);
      strike     <= (state_nxt == S_STRIKE);
      hit_player <= (state_nxt == S_STRIKE) && (x_pos == px) && !player_block;
      blocked    <= (state_nxt == S_STRIKE) && (x_pos == px) &&  player_block;
      stunned    <= (state_nxt == S_STUN);
    end
  end

endmodule
